count_ones_collect: RTL and testbench
=====================================

COUNT_ONES_COLLECT -- requirements
Module: count_ones_collect

Interface
REQ-001 Parameter COUNT_SIZE, default 3: width of the incoming bit_count result.
REQ-002 Parameter DEPTH, default 4: result FIFO depth; power of two, minimum 2.
REQ-003 Parameter TOTAL_SIZE, default 8: width of the running ones total.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 bit_count  input  COUNT_SIZE  result from the upstream ones counter; valid while done is high.
REQ-007 done  input  1  upstream completion flag; may stay high for several cycles.
REQ-008 out_ready  input  1  downstream consumer accepts out_data.
REQ-009 clear_stats  input  1  synchronous clear of total, word_cnt and overflow.
REQ-010 out_data  output  COUNT_SIZE  FIFO head entry (first-word fall-through).
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 full  output  1  FIFO holds DEPTH entries.
REQ-013 total  output  TOTAL_SIZE  saturating sum of accepted results.
REQ-014 word_cnt  output  TOTAL_SIZE  saturating count of accepted results.
REQ-015 overflow  output  1  sticky flag: a result was dropped.

Function
REQ-016 Register done into done_prev each cycle; a capture event is done=1 and done_prev=0 at a rising edge.
REQ-017 Exactly one capture per done pulse, however long done stays high.
REQ-018 On a capture with FIFO not full, write bit_count at the tail at that edge; out_valid is high after the same edge (latency 1).
REQ-019 A pop occurs at an edge where out_valid=1 and out_ready=1; the head advances.
REQ-020 Capture and pop at the same edge with FIFO full: both occur; occupancy stays DEPTH; no drop.
REQ-021 Capture and pop at the same edge with FIFO empty: no pop; the capture is written.
REQ-022 Capture when full without a pop: result discarded, FIFO unchanged, overflow set at that edge.
REQ-023 Read and write pointers wrap modulo DEPTH; occupancy counter spans 0..DEPTH.
REQ-024 On each accepted capture, total += bit_count (zero-extended) and word_cnt += 1, each saturating at all-ones.
REQ-025 Discarded captures do not change total or word_cnt.
REQ-026 clear_stats=1 zeroes total, word_cnt and overflow at the edge and takes priority over a same-edge accumulate or overflow set.
REQ-027 clear_stats does not affect FIFO contents or pointers.
REQ-028 out_data is undefined-but-stable (last head) when out_valid=0; consumers ignore it.

Reset
REQ-029 reset=0 asynchronously clears pointers, occupancy, done_prev, total, word_cnt and overflow.
REQ-030 During reset, out_valid=0, full=0, out_data=0.
REQ-031 A done held high through reset release does not capture until done falls and rises again (done_prev resets to 1).

Configuration
REQ-032 With COUNT_ONES_PARITY_EN defined, add output out_parity (1 bit) = XOR of out_data bits, stored per entry at capture; it resets to 0.
REQ-033 Without COUNT_ONES_PARITY_EN, out_parity is absent and no parity storage exists.

Verification
REQ-034 Reset, then done pulses with bit_count 4, 2, 2, 3 and out_ready=0 -> full=1 after the 4th; total=11, word_cnt=4.
REQ-035 From full, 5th done pulse with bit_count 1 and out_ready=0 -> overflow=1; total stays 11; FIFO still 4,2,2,3.
REQ-036 done held high for 6 cycles with bit_count 3 -> exactly one entry; word_cnt +1.
REQ-037 FIFO full, out_ready=1 and a done rise with bit_count 0 at the same edge -> pops 4, writes 0; full stays 1; no overflow.
REQ-038 Drain with out_ready=1 -> out_data sequence 2,2,3,0; out_valid falls after the last pop; clear_stats pulse -> total=0, overflow=0.
REQ-039 Assert reset mid-drain -> out_valid=0 immediately (asynchronously); with COUNT_ONES_PARITY_EN, entry 3 -> out_parity=0, entry 4 -> out_parity=1.

Source files
------------

// File: rtl/count_ones_collect.sv
// Collects bit_count results on each rising edge of done into a small FWFT FIFO and keeps saturating statistics.
// Optional per-entry parity output is enabled by defining COUNT_ONES_PARITY_EN.
module count_ones_collect #(
    parameter int COUNT_SIZE = 3,
    parameter int DEPTH      = 4,
    parameter int TOTAL_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COUNT_SIZE-1:0] bit_count,
    input  logic                  done,
    input  logic                  out_ready,
    input  logic                  clear_stats,
    output logic [COUNT_SIZE-1:0] out_data,
    output logic                  out_valid,
    output logic                  full,
    output logic [TOTAL_SIZE-1:0] total,
    output logic [TOTAL_SIZE-1:0] word_cnt,
`ifdef COUNT_ONES_PARITY_EN
    output logic                  out_parity,
`endif
    output logic                  overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = TOTAL_SIZE + 1;

    logic                  done_prev;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      occupancy;
    logic [COUNT_SIZE-1:0] mem [DEPTH];
`ifdef COUNT_ONES_PARITY_EN
    logic                  par_mem [DEPTH];
`endif

    logic                  capture;
    logic                  pop;
    logic                  accept;
    logic                  drop;
    logic [SUM_W-1:0]      total_sum;
    logic [TOTAL_SIZE-1:0] total_next;
    logic [TOTAL_SIZE-1:0] word_cnt_next;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        out_valid = (occupancy != '0);
        full      = (occupancy == CNT_W'(DEPTH));
        capture   = done && !done_prev;
        pop       = out_valid && out_ready;
        // A full FIFO still accepts when the head leaves at the same edge.
        accept    = capture && (!full || pop);
        drop      = capture && full && !pop;

        total_sum     = {1'b0, total} + SUM_W'(bit_count);
        total_next    = total_sum[TOTAL_SIZE] ? '1 : total_sum[TOTAL_SIZE-1:0];
        word_cnt_next = (word_cnt == '1) ? word_cnt : word_cnt + TOTAL_SIZE'(1);

        out_data = mem[rd_ptr];
`ifdef COUNT_ONES_PARITY_EN
        out_parity = par_mem[rd_ptr];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Held high so a done already asserted at reset release is not a new pulse.
            done_prev <= 1'b1;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            done_prev <= done;
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (accept && !pop) begin
                occupancy <= occupancy + CNT_W'(1);
            end else if (pop && !accept) begin
                occupancy <= occupancy - CNT_W'(1);
            end
        end
    end

    // NOTE: storage is reset too, because out_data must read 0 during reset; it is tiny.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[wr_ptr] <= bit_count;
        end
    end

`ifdef COUNT_ONES_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_mem[i] <= 1'b0;
            end
        end else if (accept) begin
            par_mem[wr_ptr] <= ^bit_count;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total    <= '0;
            word_cnt <= '0;
            overflow <= 1'b0;
        end else if (clear_stats) begin
            total    <= '0;
            word_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                total    <= total_next;
                word_cnt <= word_cnt_next;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_ones_collect.sv
// Self-checking bench for count_ones_collect: directed scenarios plus randomized traffic against a queue model.
// Parity checks are compiled in when COUNT_ONES_PARITY_EN is defined.
module tb_count_ones_collect;

    localparam int COUNT_SIZE = 3;
    localparam int DEPTH      = 4;
    localparam int TOTAL_SIZE = 8;
    localparam int SAT_MAX    = (1 << TOTAL_SIZE) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [COUNT_SIZE-1:0] bit_count;
    logic                  done;
    logic                  out_ready;
    logic                  clear_stats;
    logic [COUNT_SIZE-1:0] out_data;
    logic                  out_valid;
    logic                  full;
    logic [TOTAL_SIZE-1:0] total;
    logic [TOTAL_SIZE-1:0] word_cnt;
    logic                  overflow;
`ifdef COUNT_ONES_PARITY_EN
    logic                  out_parity;
`endif

    count_ones_collect #(
        .COUNT_SIZE (COUNT_SIZE),
        .DEPTH      (DEPTH),
        .TOTAL_SIZE (TOTAL_SIZE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_count   (bit_count),
        .done        (done),
        .out_ready   (out_ready),
        .clear_stats (clear_stats),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .full        (full),
        .total       (total),
        .word_cnt    (word_cnt),
`ifdef COUNT_ONES_PARITY_EN
        .out_parity  (out_parity),
`endif
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int q[$];
    int m_total;
    int m_word_cnt;
    bit m_overflow;
    bit m_done_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_total     = 0;
        m_word_cnt  = 0;
        m_overflow  = 1'b0;
        m_done_prev = 1'b1;
    endtask

    // Behaviour at one rising edge, from the current inputs.
    task automatic model_step();
        bit cap;
        bit popped;
        bit accepted;
        cap         = done && !m_done_prev;
        m_done_prev = done;
        popped      = (q.size() != 0) && out_ready;
        if (popped) void'(q.pop_front());
        accepted = 1'b0;
        if (cap) begin
            if (q.size() < DEPTH) begin
                q.push_back(int'(bit_count));
                accepted = 1'b1;
            end
        end
        if (clear_stats) begin
            m_total    = 0;
            m_word_cnt = 0;
            m_overflow = 1'b0;
        end else begin
            if (accepted) begin
                m_total    = (m_total + int'(bit_count) > SAT_MAX) ? SAT_MAX : m_total + int'(bit_count);
                m_word_cnt = (m_word_cnt + 1 > SAT_MAX) ? SAT_MAX : m_word_cnt + 1;
            end
            if (cap && !accepted) m_overflow = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("total", 32'(total), 32'(m_total));
        check("word_cnt", 32'(word_cnt), 32'(m_word_cnt));
        check("overflow", 32'(overflow), 32'(m_overflow));
        if (q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(q[0]));
`ifdef COUNT_ONES_PARITY_EN
            check("out_parity", 32'(out_parity), 32'(^q[0][COUNT_SIZE-1:0]));
`endif
        end
    endtask

    // Inputs are set after a falling edge; this advances one rising edge and compares at the next falling edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse(input int bc, input logic rdy);
        done      = 1'b1;
        bit_count = COUNT_SIZE'(bc);
        out_ready = rdy;
        cycle();
        done = 1'b0;
        cycle();
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_total"}, 32'(total), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
`ifdef COUNT_ONES_PARITY_EN
        check({tag, "_parity"}, 32'(out_parity), 32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int drain_exp[4];
        reset       = 1'b0;
        done        = 1'b0;
        bit_count   = '0;
        out_ready   = 1'b0;
        clear_stats = 1'b0;
        model_reset();
        #12;
        check_in_reset("reset");
        @(negedge clk);
        reset = 1'b1;
        cycle();

        // Fill with 4,2,2,3 and no consumer.
        pulse(4, 1'b0);
        pulse(2, 1'b0);
        pulse(2, 1'b0);
        pulse(3, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_total", 32'(total), 32'd11);
        check("fill_wcnt", 32'(word_cnt), 32'd4);

        // Fifth result while full is dropped.
        pulse(1, 1'b0);
        check("drop_ovf", 32'(overflow), 32'd1);
        check("drop_total", 32'(total), 32'd11);
        check("drop_head", 32'(out_data), 32'd4);

        // Simultaneous pop and capture while full.
        done = 1'b1; bit_count = 3'd0; out_ready = 1'b1;
        cycle();
        done = 1'b0; out_ready = 1'b0;
        cycle();
        check("swap_full", 32'(full), 32'd1);
        check("swap_head", 32'(out_data), 32'd2);
        check("swap_wcnt", 32'(word_cnt), 32'd5);
        check("swap_total", 32'(total), 32'd11);

        // Drain and observe the order.
        drain_exp = '{2, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), 32'(out_data), 32'(drain_exp[i]));
            out_ready = 1'b1;
            cycle();
        end
        check("drain_empty", 32'(out_valid), 32'd0);
        out_ready   = 1'b0;
        clear_stats = 1'b1;
        cycle();
        clear_stats = 1'b0;
        check("clear_total", 32'(total), 32'd0);
        check("clear_wcnt", 32'(word_cnt), 32'd0);
        check("clear_ovf", 32'(overflow), 32'd0);

        // Long done yields a single capture.
        done = 1'b1; bit_count = 3'd3;
        for (int i = 0; i < 6; i++) cycle();
        done = 1'b0;
        cycle();
        check("long_wcnt", 32'(word_cnt), 32'd1);
        check("long_total", 32'(total), 32'd3);
        pulse(4, 1'b0);
        check("long_head", 32'(out_data), 32'd3);
`ifdef COUNT_ONES_PARITY_EN
        check("par_entry3", 32'(out_parity), 32'd0);
`endif
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("long_single", 32'(out_data), 32'd4);
`ifdef COUNT_ONES_PARITY_EN
        check("par_entry4", 32'(out_parity), 32'd1);
`endif

        // Asynchronous reset in the middle of a drain.
        out_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_in_reset("async");
        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        // done held through reset release must not capture.
        for (int i = 0; i < 3; i++) cycle();
        check("held_done_nocap", 32'(out_valid), 32'd0);
        done = 1'b0;
        cycle();

        // Randomized traffic: a congested phase, then a free-flowing phase.
        for (int i = 0; i < 3000; i++) begin
            done        = ($urandom_range(0, 2) != 0);
            bit_count   = COUNT_SIZE'($urandom);
            out_ready   = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clear_stats = ($urandom_range(0, 999) == 0);
            cycle();
        end
        done = 1'b0; out_ready = 1'b0; clear_stats = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
